// File: rtl/qar_alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qar_alarm_pkg
// Brief    : Shared constants and types for the qar_alarm_sched alarm block:
//            register word addresses, FSM state type, default slot count.
// Revision : 1.0 - initial release
// ============================================================================
package qar_alarm_pkg;

    localparam int c_NUM_SLOTS_DEFAULT = 4;
    localparam int c_IDX_W             = 2;

    localparam logic [5:0] c_ADDR_CTRL       = 6'h00;
    localparam logic [5:0] c_ADDR_PENDING    = 6'h01;
    localparam logic [5:0] c_ADDR_IRQ_EN     = 6'h02;
    localparam logic [5:0] c_ADDR_ARM        = 6'h03;
    localparam logic [5:0] c_ADDR_STATUS     = 6'h04;
    localparam logic [5:0] c_ADDR_NEXT_DELTA = 6'h06;
    localparam logic [5:0] c_ADDR_SLOT_BASE  = 6'h08;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/qar_alarm_slot_regs.sv
`default_nettype none
// ============================================================================
// Module   : qar_alarm_slot_regs
// Brief    : Per-slot DEADLINE / PERIOD / armed storage. Offers a bus read
//            port, a bus write port, and an indexed read/update port that the
//            scan uses to reload or disarm the slot it is evaluating.
// Revision : 1.0 - initial release
// ============================================================================
module qar_alarm_slot_regs
    import qar_alarm_pkg::*;
#(
    parameter int NUM_SLOTS = c_NUM_SLOTS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_bus_wr,
    input  logic [c_IDX_W-1:0]   i_bus_slot,
    input  logic                 i_bus_field,
    input  logic [31:0]          i_bus_wdata,
    input  logic                 i_arm_wr,
    input  logic [NUM_SLOTS-1:0] i_arm_wdata,
    input  logic [c_IDX_W-1:0]   i_rd_slot,
    output logic [31:0]          o_rd_deadline,
    output logic [31:0]          o_rd_period,
    input  logic [c_IDX_W-1:0]   i_scan_idx,
    output logic [31:0]          o_scan_deadline,
    output logic [31:0]          o_scan_period,
    output logic                 o_scan_armed,
    input  logic                 i_scan_reload,
    input  logic                 i_scan_disarm,
    output logic [NUM_SLOTS-1:0] o_armed
);

    logic [31:0]          r_deadline [NUM_SLOTS];
    logic [31:0]          r_period   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_armed;

    // Slot storage: bus writes take priority over the scan's reload/disarm
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_deadline[i] <= '0;
                r_period[i]   <= '0;
            end
            r_armed <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (i_bus_wr && int'(i_bus_slot) == i) begin
                    if (i_bus_field) r_period[i]   <= i_bus_wdata;
                    else             r_deadline[i] <= i_bus_wdata;
                end else if (i_scan_reload && int'(i_scan_idx) == i) begin
                    r_deadline[i] <= r_deadline[i] + r_period[i];
                end
            end
            if (i_arm_wr) begin
                r_armed <= i_arm_wdata;
            end else if (i_scan_disarm) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (int'(i_scan_idx) == i) r_armed[i] <= 1'b0;
                end
            end
        end
    end

    // Indexed read muxes for the bus and for the scan
    always_comb begin
        o_rd_deadline   = '0;
        o_rd_period     = '0;
        o_scan_deadline = '0;
        o_scan_period   = '0;
        o_scan_armed    = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (int'(i_rd_slot) == i) begin
                o_rd_deadline = r_deadline[i];
                o_rd_period   = r_period[i];
            end
            if (int'(i_scan_idx) == i) begin
                o_scan_deadline = r_deadline[i];
                o_scan_period   = r_period[i];
                o_scan_armed    = r_armed[i];
            end
        end
    end

    assign o_armed = r_armed;

endmodule
`default_nettype wire

// File: rtl/qar_alarm_sched.sv
`default_nettype none
// ============================================================================
// Module   : qar_alarm_sched
// Brief    : Alarm scheduler. On each enabled timer tick, scans the alarm
//            slots one per cycle, sets PENDING on exact deadline matches and
//            reloads periodic slots or disarms one-shot slots.
// Config   : define QAR_ALARM_SCHED_NEXT_EN to build the next-deadline
//            tracker (NEXT_DELTA); otherwise NEXT_DELTA reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module qar_alarm_sched
    import qar_alarm_pkg::*;
#(
    parameter int NUM_SLOTS = c_NUM_SLOTS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [31:0] count,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [5:0]  addr_word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        busy
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_enable;
    logic                 r_overrun;
    logic [NUM_SLOTS-1:0] r_pending;
    logic [NUM_SLOTS-1:0] r_irq_en;
    logic [31:0]          r_snap;
    logic [c_IDX_W-1:0]   r_idx;

    logic                 w_sel_slot, w_wr_slot, w_wr_arm, w_wr_ctrl;
    logic                 w_wr_pend, w_wr_ien, w_wr_status;
    logic                 w_scan, w_start, w_abort, w_conflict, w_eval, w_last;
    logic                 w_match, w_scan_reload, w_scan_disarm;
    logic [NUM_SLOTS-1:0] w_pend_set, w_pend_clr, w_armed;
    logic [31:0]          w_rd_deadline, w_rd_period;
    logic [31:0]          w_scan_deadline, w_scan_period;
    logic                 w_scan_armed;
    logic [31:0]          w_next_delta;

    // Address decode; slot registers live at 0x8 + 2*slot + field
    assign w_sel_slot  = (addr_word[5:3] == c_ADDR_SLOT_BASE[5:3]) && (int'(addr_word[2:1]) < NUM_SLOTS);
    assign w_wr_slot   = bus_write && w_sel_slot;
    assign w_wr_arm    = bus_write && (addr_word == c_ADDR_ARM);
    assign w_wr_ctrl   = bus_write && (addr_word == c_ADDR_CTRL);
    assign w_wr_pend   = bus_write && (addr_word == c_ADDR_PENDING);
    assign w_wr_ien    = bus_write && (addr_word == c_ADDR_IRQ_EN);
    assign w_wr_status = bus_write && (addr_word == c_ADDR_STATUS);

    // Scan control: a bus write touching the slot under evaluation wins and
    // skips it; clearing enable stops the scan without evaluating further.
    assign w_scan        = (r_state == ST_SCAN);
    assign w_start       = (r_state == ST_IDLE) && tick && r_enable;
    assign w_abort       = w_scan && w_wr_ctrl && !wdata[0];
    assign w_conflict    = w_wr_arm || (w_wr_slot && addr_word[2:1] == r_idx);
    assign w_eval        = w_scan && !w_abort && !w_conflict;
    assign w_last        = (int'(r_idx) == NUM_SLOTS - 1);
    assign w_match       = w_eval && w_scan_armed && (w_scan_deadline == r_snap);
    assign w_scan_reload = w_match && (w_scan_period != 32'h0);
    assign w_scan_disarm = w_match && (w_scan_period == 32'h0);
    assign w_pend_clr    = w_wr_pend ? wdata[NUM_SLOTS-1:0] : '0;

    qar_alarm_slot_regs #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot_regs (
        .clk             (clk),
        .rst             (rst),
        .i_bus_wr        (w_wr_slot),
        .i_bus_slot      (addr_word[2:1]),
        .i_bus_field     (addr_word[0]),
        .i_bus_wdata     (wdata),
        .i_arm_wr        (w_wr_arm),
        .i_arm_wdata     (wdata[NUM_SLOTS-1:0]),
        .i_rd_slot       (addr_word[2:1]),
        .o_rd_deadline   (w_rd_deadline),
        .o_rd_period     (w_rd_period),
        .i_scan_idx      (r_idx),
        .o_scan_deadline (w_scan_deadline),
        .o_scan_period   (w_scan_period),
        .o_scan_armed    (w_scan_armed),
        .i_scan_reload   (w_scan_reload),
        .i_scan_disarm   (w_scan_disarm),
        .o_armed         (w_armed)
    );

    // One-hot pending set for the slot that matched this cycle
    always_comb begin
        w_pend_set = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_match && int'(r_idx) == i) w_pend_set[i] = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state: IDLE starts on an enabled tick, SCAN ends after the last slot
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_SCAN;
            ST_SCAN: if (w_abort || w_last) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Control/status registers and scan bookkeeping; set wins over W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable  <= 1'b0;
            r_overrun <= 1'b0;
            r_pending <= '0;
            r_irq_en  <= '0;
            r_snap    <= '0;
            r_idx     <= '0;
        end else begin
            if (w_wr_ctrl) r_enable <= wdata[0];
            if (w_wr_ien)  r_irq_en <= wdata[NUM_SLOTS-1:0];
            r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
            r_overrun <= (r_overrun & ~(w_wr_status & wdata[0])) | (w_scan & tick);
            if (w_start) begin
                r_snap <= count;
                r_idx  <= '0;
            end else if (w_scan) begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
        end
    end

`ifdef QAR_ALARM_SCHED_NEXT_EN
    logic [31:0] r_min, r_next_delta, w_slot_delta, w_min_in, w_min_new;

    // Distance from snap to this slot's post-reload deadline; unarmed slots give all-ones
    always_comb begin
        w_slot_delta = '1;
        if (w_scan_armed && !w_scan_disarm) begin
            w_slot_delta = (w_scan_reload ? (w_scan_deadline + w_scan_period) : w_scan_deadline) - r_snap;
        end
        w_min_in  = (r_idx == '0) ? '1 : r_min;
        w_min_new = (w_slot_delta < w_min_in) ? w_slot_delta : w_min_in;
    end

    // Running minimum across the scan, published when the last slot is done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min        <= '0;
            r_next_delta <= '0;
        end else if (w_scan && !w_abort) begin
            r_min <= w_min_new;
            if (w_last) r_next_delta <= w_min_new;
        end
    end

    assign w_next_delta = r_next_delta;
`else
    assign w_next_delta = '0;
`endif

    // Combinational register read
    always_comb begin
        rdata = '0;
        if (bus_read && !rst) begin
            if (w_sel_slot) begin
                rdata = addr_word[0] ? w_rd_period : w_rd_deadline;
            end else begin
                case (addr_word)
                    c_ADDR_CTRL:       rdata = {31'b0, r_enable};
                    c_ADDR_PENDING:    rdata = 32'(r_pending);
                    c_ADDR_IRQ_EN:     rdata = 32'(r_irq_en);
                    c_ADDR_ARM:        rdata = 32'(w_armed);
                    c_ADDR_STATUS:     rdata = {30'b0, w_scan, r_overrun};
                    c_ADDR_NEXT_DELTA: rdata = w_next_delta;
                    default:           rdata = '0;
                endcase
            end
        end
    end

    assign irq  = (|(r_pending & r_irq_en)) && !rst;
    assign busy = w_scan && !rst;

endmodule
`default_nettype wire

// File: doc/qar_alarm_sched.md
QAR_ALARM_SCHED -- requirements
Module: qar_alarm_sched

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, giving the number of alarm slots (legal range 1..4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port tick, input, 1 bit: one-cycle strobe, asserted when the timer counter increments.
REQ-005 SHALL have port count, input, 32 bits: timer counter value, valid in the tick cycle.
REQ-006 SHALL have ports bus_write (in, 1), bus_read (in, 1), addr_word (in, 6), wdata (in, 32): word-addressed register access.
REQ-007 SHALL have port rdata, output, 32 bits: combinational read data; 0 when bus_read is low or the address is unmapped.
REQ-008 SHALL have port irq, output, 1 bit: |(PENDING & IRQ_EN).
REQ-009 SHALL have port busy, output, 1 bit: high while the FSM is in SCAN.

Function
REQ-010 Register map SHALL be: 0x0 CTRL (bit0 enable); 0x1 PENDING (W1C); 0x2 IRQ_EN; 0x3 ARM; 0x4 STATUS; 0x6 NEXT_DELTA (RO); 0x8+2i DEADLINE_i; 0x9+2i PERIOD_i.
REQ-011 ARM writes SHALL be a per-slot mask: 1 arms slot i, 0 disarms it; ARM reads SHALL return the armed mask.
REQ-012 STATUS SHALL be: bit0 overrun (sticky, W1C); bit1 busy (read-only).
REQ-013 FSM SHALL have two states, IDLE and SCAN.
REQ-014 IDLE -> SCAN SHALL occur on tick when CTRL.enable is 1: latch count into snap, set idx to 0.
REQ-015 Each SCAN cycle SHALL evaluate slot idx: if armed and DEADLINE==snap, set PENDING[idx].
REQ-016 On a match, if PERIOD!=0 then DEADLINE <= DEADLINE+PERIOD (32-bit, wraps mod 2^32); otherwise disarm the slot.
REQ-017 SCAN SHALL increment idx each cycle and return to IDLE after slot NUM_SLOTS-1 is evaluated.
REQ-018 Latency SHALL be: tick in cycle T evaluates slot i in cycle T+1+i; PENDING[i] and irq are visible at T+2+i.
REQ-019 A tick while in SCAN SHALL be dropped and SHALL set STATUS.overrun.
REQ-020 A tick while CTRL.enable is 0 SHALL be ignored, with no overrun.
REQ-021 Clearing CTRL.enable mid-scan SHALL return the FSM to IDLE next cycle; remaining slots are not evaluated.
REQ-022 A bus write to DEADLINE_i, PERIOD_i or ARM in the cycle slot i is evaluated SHALL win; that slot's evaluation is skipped.
REQ-023 A PENDING W1C in the same cycle a match sets the same bit SHALL leave the bit set (set wins).
REQ-024 Deadline compare SHALL be equality only; a deadline already passed does not fire until count wraps.

Reset
REQ-025 On rst, CTRL, PENDING, IRQ_EN, ARM mask, STATUS, all DEADLINE/PERIOD, snap, idx and NEXT_DELTA SHALL be 0, and the FSM SHALL be IDLE.
REQ-026 The outputs irq, busy and rdata SHALL be 0 during and after reset.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no pending bit set.

Configuration
REQ-028 Macro QAR_ALARM_SCHED_NEXT_EN SHALL enable the next-deadline tracker.
REQ-029 With the macro defined, each scan SHALL compute min(DEADLINE-snap) over armed slots, using post-reload deadlines, and write it to NEXT_DELTA at scan end; the value is 0xFFFFFFFF if no slot is armed.
REQ-030 Without the macro, NEXT_DELTA SHALL read 0 and no tracker logic SHALL exist.

Structure
REQ-031 Package qar_alarm_pkg SHALL hold the register address constants, the FSM state typedef, and the NUM_SLOTS default.
REQ-032 Sub-module qar_alarm_slot_regs SHALL hold the per-slot DEADLINE, PERIOD and armed storage, with an indexed read/update port used by the scan; no other sub-modules.

Verification
REQ-033 Scenario: DEADLINE0=5, PERIOD0=0, ARM=1, IRQ_EN=1, enable; tick with count=5 -> PENDING=0x1 and irq at T+2; slot 0 disarmed.
REQ-034 Scenario: DEADLINE1=0xFFFFFFFE, PERIOD1=4; tick with count=0xFFFFFFFE -> PENDING[1] set, DEADLINE1=0x00000002.
REQ-035 Scenario: two ticks 2 cycles apart with NUM_SLOTS=4 -> second tick dropped, STATUS=0x1 after the scan ends; W1C of 0x1 clears it.
REQ-036 Scenario: write DEADLINE2=0x100 in the cycle slot 2 evaluates a matching snap -> PENDING[2] stays 0, DEADLINE2 reads 0x100.
REQ-037 Scenario: slots 0 and 3 match the same tick -> PENDING[0] at T+2, PENDING[3] at T+5, busy high for exactly 4 cycles.
REQ-038 Scenario (NEXT_EN): slots at 10 and 30, tick with count=7 -> NEXT_DELTA=3.
